// File: rtl/lc3b_dcache.sv
// lc3b_dcache: direct-mapped, write-back, write-allocate data cache for the
// LC-3b datapath. 8 sets x 16-byte lines. Address = tag[15:7] | index[6:4] |
// offset[3:0]; the word select is offset[3:1].
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   mem_address/read/write/wmask/wdata   CPU request, held until mem_resp
//   mem_rdata, mem_resp             read data and one-cycle completion pulse
//   pmem_address/read/write/wdata   line transfer request, held until pmem_resp
//   pmem_rdata, pmem_resp           fill line and one-cycle pmem completion
//
// state     | meaning
// IDLE      | look up a request; hit -> RESPOND, miss -> WRITEBACK or FILL
// WRITEBACK | dirty victim line being written to pmem
// FILL      | requested line being read from pmem
// RESPOND   | mem_resp pulse for one cycle
module lc3b_dcache (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_wmask,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, RESPOND} state_t;

    state_t state, state_next;

    logic [7:0]   valid;
    logic [7:0]   dirty;
    logic [8:0]   tag_arr  [8];
    logic [127:0] data_arr [8];

    logic [8:0]   req_tag;
    logic [2:0]   req_idx;
    logic [2:0]   req_word;
    logic         req;
    logic         hit;
    logic         victim_dirty;
    logic [127:0] merged_line;

    // Tag/index of the outstanding miss, so the transfer finishes on the
    // right set even if the CPU drops its request part way through.
    logic [8:0]   miss_tag;
    logic [2:0]   miss_idx;

    logic         addr_unused;
    assign addr_unused = mem_address[0];

    assign req_tag      = mem_address[15:7];
    assign req_idx      = mem_address[6:4];
    assign req_word     = mem_address[3:1];
    assign req          = mem_read | mem_write;
    assign hit          = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign victim_dirty = valid[req_idx] && dirty[req_idx];

    always_comb begin
        merged_line = data_arr[req_idx];
        if (mem_wmask[0]) merged_line[{req_word, 4'h0} +: 8] = mem_wdata[7:0];
        if (mem_wmask[1]) merged_line[{req_word, 4'h8} +: 8] = mem_wdata[15:8];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit)               state_next = RESPOND;
                    else if (victim_dirty) state_next = WRITEBACK;
                    else                   state_next = FILL;
                end
            end
            WRITEBACK: if (pmem_resp) state_next = FILL;
            FILL:      if (pmem_resp) state_next = IDLE;
            RESPOND:   state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Outputs decoded from the state register only, so no path from
    // pmem_resp reaches the strobes.
    always_comb begin
        mem_resp   = (state == RESPOND);
        pmem_write = (state == WRITEBACK);
        pmem_read  = (state == FILL);
    end

    // Status bits and registered datapath outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid        <= '0;
            dirty        <= '0;
            mem_rdata    <= '0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            miss_tag     <= '0;
            miss_idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        miss_tag <= req_tag;
                        miss_idx <= req_idx;
                        if (hit) begin
                            // Write takes priority if both strobes are high.
                            if (mem_write) dirty[req_idx] <= 1'b1;
                            else           mem_rdata <= data_arr[req_idx][{req_word, 4'h0} +: 16];
                        end else if (victim_dirty) begin
                            pmem_wdata   <= data_arr[req_idx];
                            pmem_address <= {tag_arr[req_idx], req_idx, 4'h0};
                        end else begin
                            pmem_address <= {req_tag, req_idx, 4'h0};
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        dirty[miss_idx] <= 1'b0;
                        pmem_address    <= {miss_tag, miss_idx, 4'h0};
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        valid[miss_idx] <= 1'b1;
                        dirty[miss_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (state == IDLE && req && hit && mem_write) begin
            data_arr[req_idx] <= merged_line;
        end else if (state == FILL && pmem_resp) begin
            data_arr[miss_idx] <= pmem_rdata;
            tag_arr[miss_idx]  <= miss_tag;
        end
    end

endmodule

// File: tb/tb_lc3b_dcache.sv
module tb_lc3b_dcache;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  mem_address = '0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [1:0]   mem_wmask = '0;
    logic [15:0]  mem_wdata = '0;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    lc3b_dcache dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wmask    (mem_wmask),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_read;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        bit           is_write;
        logic [15:0]  addr;
        logic [127:0] wdata;
        int           cyc;
    } pm_t;

    exp_t         exp_q[$];
    pm_t          pm_log[$];
    logic [127:0] pmem_mem [logic [11:0]];
    int           lat = 3;
    int           cyc = 0;
    int           t0 = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    logic [127:0] line_a, line_b, line_c, exp_wb;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Physical memory model: answers each strobe after lat extra cycles.
    initial begin
        int cnt;
        pm_t e;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pmem_resp = 1'b0;
                cnt = 0;
            end else if (pmem_resp) begin
                pmem_resp = 1'b0;
                cnt = 0;
            end else if (pmem_read || pmem_write) begin
                if (cnt >= lat) begin
                    e.is_write = pmem_write;
                    e.addr     = pmem_address;
                    e.wdata    = pmem_wdata;
                    e.cyc      = cyc;
                    pm_log.push_back(e);
                    if (pmem_write) pmem_mem[pmem_address[15:4]] = pmem_wdata;
                    else pmem_rdata = pmem_mem.exists(pmem_address[15:4]) ? pmem_mem[pmem_address[15:4]] : '0;
                    pmem_resp = 1'b1;
                    cnt = 0;
                end else begin
                    cnt = cnt + 1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_req(input logic [15:0] a, input bit wr,
                             input logic [15:0] wd, input logic [1:0] wm);
        @(posedge clk);
        #1;
        mem_address = a;
        mem_read    = !wr;
        mem_write   = wr;
        mem_wdata   = wd;
        mem_wmask   = wm;
        t0          = cyc;
    endtask

    // Waits (bounded) for mem_resp; returns latency in cycles and the data.
    task automatic wait_resp(output bit ok, output int latency,
                             output logic [15:0] rd, output int rcyc);
        ok = 1'b0;
        latency = -1;
        rd = 'x;
        rcyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_resp) begin
                ok = 1'b1;
                latency = cyc - t0;
                rd = mem_rdata;
                rcyc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (mem_resp !== 1'b0) begin n_fail++; $display("FAIL reset_mem_resp: got %b expected 0", mem_resp); end
        n_checks++; if (mem_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_mem_rdata: got %h expected 0000", mem_rdata); end
        n_checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got rd=%b wr=%b expected 0 0", pmem_read, pmem_write); end
        n_checks++; if (pmem_address !== 16'h0) begin n_fail++; $display("FAIL reset_pmem_address: got %h expected 0000", pmem_address); end
        n_checks++; if (pmem_wdata !== 128'h0) begin n_fail++; $display("FAIL reset_pmem_wdata: got %h expected 0", pmem_wdata); end
        rst_n = 1'b1;
    endtask

    task automatic check_pop(input string name, input logic [15:0] rd);
        exp_t x;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got response %h but scoreboard empty", name, rd);
        end else begin
            x = exp_q.pop_front();
            if (x.is_read && rd !== x.data) begin
                n_fail++;
                $display("FAIL %s: got rdata %h expected %h", name, rd, x.data);
            end
        end
    endtask

    task automatic test_cold_read();
        bit ok; int l; logic [15:0] rd; int rc; int base;
        base = pm_log.size();
        start_req(16'h1234, 1'b0, 16'h0, 2'b00);
        exp_q.push_back('{1'b1, 16'hBEEF});
        wait_resp(ok, l, rd, rc);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL cold_resp: got timeout expected mem_resp"); end
        check_pop("cold_rdata", rd);
        n_checks++;
        if (pm_log.size() != base + 1) begin
            n_fail++; $display("FAIL cold_pmem_count: got %0d expected %0d", pm_log.size() - base, 1);
        end else begin
            if (pm_log[base].is_write || pm_log[base].addr !== 16'h1230) begin
                n_fail++; $display("FAIL cold_pmem_read: got wr=%b addr=%h expected read 1230", pm_log[base].is_write, pm_log[base].addr);
            end
            n_checks++; if (rc - pm_log[base].cyc != 2) begin n_fail++; $display("FAIL cold_resp_delay: got %0d expected 2", rc - pm_log[base].cyc); end
        end
        n_checks++; if (l != lat + 3) begin n_fail++; $display("FAIL cold_latency: got %0d expected %0d", l, lat + 3); end
    endtask

    task automatic test_hit();
        bit ok; int l; logic [15:0] rd; int rc; int base;
        base = pm_log.size();
        start_req(16'h1234, 1'b0, 16'h0, 2'b00);
        exp_q.push_back('{1'b1, 16'hBEEF});
        wait_resp(ok, l, rd, rc);
        n_checks++; if (l != 1) begin n_fail++; $display("FAIL hit_latency: got %0d expected 1", l); end
        check_pop("hit_rdata", rd);
        n_checks++; if (pm_log.size() != base) begin n_fail++; $display("FAIL hit_no_pmem: got %0d transfers expected 0", pm_log.size() - base); end
    endtask

    task automatic test_byte_write();
        bit ok; int l; logic [15:0] rd; int rc;
        start_req(16'h1234, 1'b1, 16'hAA55, 2'b01);
        exp_q.push_back('{1'b0, 16'h0});
        wait_resp(ok, l, rd, rc);
        n_checks++; if (l != 1) begin n_fail++; $display("FAIL bwrite_latency: got %0d expected 1", l); end
        check_pop("bwrite_resp", rd);
        start_req(16'h1234, 1'b0, 16'h0, 2'b00);
        exp_q.push_back('{1'b1, 16'hBE55});
        wait_resp(ok, l, rd, rc);
        n_checks++; if (l != 1) begin n_fail++; $display("FAIL bwrite_read_latency: got %0d expected 1", l); end
        check_pop("bwrite_readback", rd);
    endtask

    task automatic test_dirty_evict();
        bit ok; int l; logic [15:0] rd; int rc; int base;
        base = pm_log.size();
        start_req(16'h9234, 1'b0, 16'h0, 2'b00);
        exp_q.push_back('{1'b1, 16'h5A5A});
        wait_resp(ok, l, rd, rc);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL evict_resp: got timeout expected mem_resp"); end
        check_pop("evict_rdata", rd);
        n_checks++;
        if (pm_log.size() != base + 2) begin
            n_fail++; $display("FAIL evict_pmem_count: got %0d expected 2", pm_log.size() - base);
        end else begin
            if (!pm_log[base].is_write || pm_log[base].addr !== 16'h1230) begin
                n_fail++; $display("FAIL evict_wb_addr: got wr=%b addr=%h expected write 1230", pm_log[base].is_write, pm_log[base].addr);
            end
            n_checks++; if (pm_log[base].wdata !== exp_wb) begin n_fail++; $display("FAIL evict_wb_data: got %h expected %h", pm_log[base].wdata, exp_wb); end
            n_checks++; if (pm_log[base + 1].is_write || pm_log[base + 1].addr !== 16'h9230) begin n_fail++; $display("FAIL evict_fill_addr: got wr=%b addr=%h expected read 9230", pm_log[base + 1].is_write, pm_log[base + 1].addr); end
            n_checks++; if (rc - pm_log[base + 1].cyc != 2) begin n_fail++; $display("FAIL evict_resp_delay: got %0d expected 2", rc - pm_log[base + 1].cyc); end
        end
    endtask

    task automatic test_abandoned();
        bit ok; int l; logic [15:0] rd; int rc; int base; bit seen; int stray;
        base = pm_log.size();
        start_req(16'h0048, 1'b0, 16'h0, 2'b00);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pmem_read) begin seen = 1'b1; break; end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL abandon_fill_start: got no pmem_read expected pmem_read"); end
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_resp) stray++;
        end
        n_checks++; if (stray != 0) begin n_fail++; $display("FAIL abandon_no_resp: got %0d mem_resp pulses expected 0", stray); end
        n_checks++; if (pm_log.size() != base + 1 || pm_log[pm_log.size() - 1].addr !== 16'h0040) begin n_fail++; $display("FAIL abandon_fill: got %0d transfers expected 1 read of 0040", pm_log.size() - base); end
        base = pm_log.size();
        start_req(16'h0048, 1'b0, 16'h0, 2'b00);
        exp_q.push_back('{1'b1, 16'hC0DE});
        wait_resp(ok, l, rd, rc);
        n_checks++; if (l != 1) begin n_fail++; $display("FAIL abandon_hit_latency: got %0d expected 1", l); end
        check_pop("abandon_hit_rdata", rd);
        n_checks++; if (pm_log.size() != base) begin n_fail++; $display("FAIL abandon_hit_no_pmem: got %0d transfers expected 0", pm_log.size() - base); end
    endtask

    task automatic test_reset_mid_wb();
        bit ok; int l; logic [15:0] rd; int rc; int base; bit seen;
        start_req(16'h9236, 1'b1, 16'h1234, 2'b11);
        exp_q.push_back('{1'b0, 16'h0});
        wait_resp(ok, l, rd, rc);
        n_checks++; if (l != 1) begin n_fail++; $display("FAIL rstwb_write_latency: got %0d expected 1", l); end
        check_pop("rstwb_write_resp", rd);
        start_req(16'h1234, 1'b0, 16'h0, 2'b00);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pmem_write) begin seen = 1'b1; break; end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rstwb_wb_start: got no pmem_write expected pmem_write"); end
        rst_n = 1'b0;
        mem_read = 1'b0;
        #1;
        n_checks++; if (pmem_write !== 1'b0 || pmem_read !== 1'b0) begin n_fail++; $display("FAIL rstwb_strobes: got wr=%b rd=%b expected 0 0", pmem_write, pmem_read); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = pm_log.size();
        start_req(16'h0048, 1'b0, 16'h0, 2'b00);
        exp_q.push_back('{1'b1, 16'hC0DE});
        wait_resp(ok, l, rd, rc);
        n_checks++; if (l != lat + 3) begin n_fail++; $display("FAIL rstwb_miss_latency: got %0d expected %0d", l, lat + 3); end
        check_pop("rstwb_miss_rdata", rd);
        n_checks++; if (pm_log.size() != base + 1 || pm_log[pm_log.size() - 1].is_write || pm_log[pm_log.size() - 1].addr !== 16'h0040) begin n_fail++; $display("FAIL rstwb_refill: got %0d transfers expected 1 read of 0040", pm_log.size() - base); end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            line_a[k*16 +: 16] = 16'h1000 + 16'(k);
            line_b[k*16 +: 16] = 16'h9000 + 16'(k);
            line_c[k*16 +: 16] = 16'h0400 + 16'(k);
        end
        line_a[47:32] = 16'hBEEF;
        line_b[47:32] = 16'h5A5A;
        line_c[79:64] = 16'hC0DE;
        exp_wb = line_a;
        exp_wb[47:32] = 16'hBE55;
        pmem_mem[12'h123] = line_a;
        pmem_mem[12'h923] = line_b;
        pmem_mem[12'h004] = line_c;

        test_reset();
        test_cold_read();
        test_hit();
        test_byte_write();
        test_dirty_evict();
        test_abandoned();
        test_reset_mid_wb();

        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3b_dcache.md
# lc3b_dcache

Direct-mapped, write-back, write-allocate cache that answers the LC-3b datapath's word-level memory requests (mem_read/mem_write/mem_wmask) and, on a miss, initiates 128-bit line transfers to physical memory. The cache has 8 sets and a 16-byte line. The address splits into tag[15:7] (9 bits), index[6:4] (3 bits) and offset[3:0] (4 bits). The block sits between the CPU memory port and the pmem port.

## Interface
- Parameters: none. Geometry is fixed: 8 sets, 9-bit tag, 128-bit line.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_address  in  16  CPU byte address; word select = offset[3:1], offset[0] ignored
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_wmask  in  2  byte enables: bit0 = low byte, bit1 = high byte
- mem_wdata  in  16  CPU write data
- mem_rdata  out  16  read data, valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse
- pmem_address  out  16  line-aligned address, low 4 bits always 0
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_wdata  out  128  writeback line
- pmem_rdata  in  128  fill line, valid with pmem_resp
- pmem_resp  in  1  pmem completion, one cycle

## Operation
- Per-set state:
  - valid (1 bit)
  - dirty (1 bit)
  - tag (9 bits)
  - data (128 bits)
- Word w of a line occupies bits [16w+15:16w].
- FSM states:
  - **IDLE:** if (mem_read|mem_write), compare the stored tag with the request tag and check valid.
    - Hit read: latch the word into mem_rdata, then go to RESPOND.
    - Hit write: merge mem_wdata into the word per mem_wmask, set dirty, then go to RESPOND.
    - Miss with the victim dirty (valid & dirty): latch the victim line into pmem_wdata, set pmem_address = {victim tag, index, 4'h0}, then go to WRITEBACK.
    - Miss otherwise: set pmem_address = {request tag, index, 4'h0}, then go to FILL.
  - **WRITEBACK:** pmem_write=1. On pmem_resp: clear dirty, load pmem_address with the fill address, then go to FILL.
  - **FILL:** pmem_read=1. On pmem_resp: write pmem_rdata into the line, set valid=1, dirty=0, tag = request tag, then go to IDLE. The lookup repeats and hits.
  - **RESPOND:** mem_resp=1 for exactly one cycle, then go to IDLE.
- mem_wmask=2'b00 on a write: the request still completes and sets dirty, but the data is unchanged.
- mem_read and mem_write both high is a protocol violation. The write takes priority; the bench flags it.
- Request dropped during WRITEBACK/FILL: the transfer completes and the line is installed. No mem_resp is issued if the request is absent when the FSM returns to IDLE.
- Request address changed mid-miss: not permitted. The CPU holds address/data stable until mem_resp.
- Reset values:
  - Async reset: all valid and dirty cleared, state = IDLE.
  - Outputs: mem_resp=0, mem_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - Tag and data arrays are not reset.
- Reset asserted mid-transfer drops the pmem strobes immediately. Any pmem_resp arriving afterward is ignored in IDLE.

## Timing
- Request present in cycle 0.
- Hit: mem_resp high in cycle 1, which is a 1-cycle latency.
- Clean miss, pmem_resp in cycle F:
  - pmem_read high during cycles 1..F.
  - Re-lookup in cycle F+1.
  - mem_resp in cycle F+2.
- Dirty miss:
  - pmem_write high during cycles 1..W.
  - pmem_read high during cycles W+1..F.
  - mem_resp in cycle F+2.
- pmem strobes are registered, with no combinational path from pmem_resp to the strobes.
- The CPU deasserts its request in the cycle after mem_resp. A request seen in IDLE is always a new request.
- pmem_address and pmem_wdata stay stable for the whole time their strobe is high.

## Test plan
- **Reset then cold read:** read 0x1234 after reset.
  - Expect pmem_read with pmem_address=0x1230.
  - Return line 0x..._BEEF_..._0000 with word 2 = 0xBEEF.
  - Expect mem_rdata=0xBEEF and mem_resp 2 cycles after pmem_resp.
- **Hit latency:** repeat the read of 0x1234.
  - Expect mem_resp the next cycle, mem_rdata=0xBEEF, and no pmem activity.
- **Byte write:** write 0x1234, mem_wdata=0xAA55, mem_wmask=2'b01.
  - Expect a 1-cycle resp.
  - A subsequent read returns 0xBE55.
- **Dirty eviction:** read 0x9234 (same index 3, tag differs).
  - Expect pmem_write with pmem_address=0x1230 and a pmem_wdata word 2 of 0xBE55.
  - Then pmem_read with pmem_address=0x9230, then mem_resp.
- **Abandoned miss:** drop mem_read during FILL.
  - Expect the line installed and no mem_resp.
  - A later read of the same address hits in 1 cycle.
- **Reset mid-WRITEBACK:** pull rst_n low while pmem_write=1.
  - Expect pmem_write=0 immediately.
  - After release, a read of a previously cached address misses.
